// File: rtl/bus_hub_pkg.sv
// Shared types and constants for the N-device bus hub.
// The bus-error read pattern is all ones; callers slice it to their own data width.
package bus_hub_pkg;

   typedef enum logic [2:0] {IDLE, DECODE, ACCESS, WAIT, RESP} hub_state_t;

   localparam int DATA_W_MAX = 1024;
   localparam logic [DATA_W_MAX-1:0] BUS_ERR_RDATA = '1;

   function automatic int mask_w(input int data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/bus_prio_enc.sv
// Priority encoder: active vector to {valid, index}, lowest set index wins.
// Purely combinational; no backpressure.
module bus_prio_enc #(
   parameter int N = 3,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  act,
   output logic          vld,
   output logic [IW-1:0] idx
);

   always_comb begin
      vld = |act;
      idx = '0;
      // Scan downward so the lowest matching index is the last one written.
      for (int i = N - 1; i >= 0; i--) begin
         if (act[i]) idx = IW'(i);
      end
   end

endmodule

// File: rtl/bus_hub_n_pl.sv
// Single host port fanned out to NDEV devices with one transaction in flight.
// Latency: device strobe 2 cycles after accept, host_ready 1 cycle after device ready; host strobes dropped while busy.
module bus_hub_n_pl
   import bus_hub_pkg::*;
#(
   parameter int NDEV    = 3,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [ADDR_W-1:0]          host_address,
   input  logic [DATA_W-1:0]          host_data_write,
   input  logic [DATA_W/8-1:0]        host_write_mask,
   input  logic                       host_ren,
   input  logic                       host_wen,
   output logic [DATA_W-1:0]          host_data_read,
   output logic                       host_ready,
   output logic                       host_error,
   output logic                       host_busy,
   output logic [NDEV*ADDR_W-1:0]     device_address,
   output logic [NDEV*DATA_W-1:0]     device_data_write,
   output logic [NDEV*(DATA_W/8)-1:0] device_write_mask,
   output logic [NDEV-1:0]            device_ren,
   output logic [NDEV-1:0]            device_wen,
   input  logic [NDEV-1:0]            device_ready,
   input  logic [NDEV*DATA_W-1:0]     device_data_read,
   input  logic [NDEV-1:0]            device_active
);

   localparam int MW = mask_w(DATA_W);
   localparam int IW = (NDEV > 1) ? $clog2(NDEV) : 1;
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   hub_state_t        state, state_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdat_q;
   logic [MW-1:0]     mask_q;
   logic              wr_q;
   logic [IW-1:0]     sel_q;
   logic [CW-1:0]     cnt_q;
   logic [DATA_W-1:0] rdat_q;
   logic              err_q;
   logic              act_vld;
   logic [IW-1:0]     act_idx;
   logic              sel_rdy;
   logic              tmo;
   logic [NDEV-1:0]   sel_oh;

   bus_prio_enc #(.N(NDEV)) u_enc (
      .act (device_active),
      .vld (act_vld),
      .idx (act_idx)
   );

   assign sel_rdy = device_ready[sel_q];
   assign tmo     = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (host_ren || host_wen) state_nxt = DECODE;
         DECODE:  state_nxt = act_vld ? ACCESS : RESP;
         ACCESS:  state_nxt = WAIT;
         WAIT:    if (sel_rdy || tmo) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q <= '0;
         wdat_q <= '0;
         mask_q <= '0;
         wr_q   <= 1'b0;
         sel_q  <= '0;
         cnt_q  <= '0;
         rdat_q <= '0;
         err_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (host_ren || host_wen) begin
               addr_q <= host_address;
               wdat_q <= host_data_write;
               mask_q <= host_write_mask;
               wr_q   <= host_wen;
            end
            DECODE: begin
               sel_q <= act_idx;
               if (!act_vld) begin
                  err_q  <= 1'b1;
                  rdat_q <= '0;
               end
            end
            ACCESS: cnt_q <= '0;
            WAIT: begin
               if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
               // A ready in the timeout cycle still completes the access normally.
               if (sel_rdy) begin
                  err_q  <= 1'b0;
                  rdat_q <= wr_q ? '0 : device_data_read[sel_q*DATA_W +: DATA_W];
               end else if (tmo) begin
                  err_q  <= 1'b1;
                  rdat_q <= BUS_ERR_RDATA[DATA_W-1:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign sel_oh            = NDEV'(1) << sel_q;
   assign host_busy         = (state != IDLE);
   assign host_ready        = (state == RESP);
   assign host_error        = host_ready & err_q;
   assign host_data_read    = rdat_q;
   assign device_address    = {NDEV{addr_q}};
   assign device_data_write = {NDEV{wdat_q}};
   assign device_write_mask = {NDEV{mask_q}};
   assign device_ren        = (state == ACCESS && !wr_q) ? sel_oh : '0;
   assign device_wen        = (state == ACCESS &&  wr_q) ? sel_oh : '0;

endmodule

// File: doc/bus_hub_n_pl.md
Name: bus_hub_n_pl

Overview:
Parametrised N-device bus hub for the SoC core bus: a single host port fans out to NDEV memory-mapped devices.
- Decodes the target from each device's own `active` address-match output.
- Sequences a one-outstanding-transaction handshake and returns read data to the host.
- Adds bus-error reporting for unmapped addresses and for devices that never respond (timeout).
- Sits between the CPU bus port and the memory, parallel-port and display devices, and replaces the fixed-count hubs.

Parameters:
NDEV, 3, number of device ports (1..16)
ADDR_W, 32, address width
DATA_W, 32, data width; mask width is DATA_W/8
TIMEOUT, 255, max cycles waiting for device_ready before a bus error; 0 disables timeout

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
host_address  in  ADDR_W  request address
host_data_write  in  DATA_W  write data
host_write_mask  in  DATA_W/8  byte write enables
host_ren  in  1  read strobe, one cycle
host_wen  in  1  write strobe, one cycle
host_data_read  out  DATA_W  read data, valid while host_ready=1
host_ready  out  1  one-cycle completion pulse
host_error  out  1  valid with host_ready; 1 = unmapped address or timeout
host_busy  out  1  transaction in flight (state != IDLE)
device_address  out  NDEV*ADDR_W  broadcast latched address; device i at [i*ADDR_W +: ADDR_W]
device_data_write  out  NDEV*DATA_W  broadcast latched write data
device_write_mask  out  NDEV*(DATA_W/8)  broadcast latched mask
device_ren  out  NDEV  one-hot read strobe
device_wen  out  NDEV  one-hot write strobe
device_ready  in  NDEV  per-device done
device_data_read  in  NDEV*DATA_W  per-device read data
device_active  in  NDEV  per-device address match for the broadcast address

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - All outputs 0, including the latched address, data and mask registers.
  - Timeout counter 0.
  - Release is synchronous to clk.
- Strobe rules:
  - Simultaneous host_ren and host_wen is treated as a write.
  - Strobes are only accepted in IDLE. Strobes arriving while host_busy=1 are dropped with no side effect.
- IDLE:
  - On host_ren|host_wen: latch address, wdata, mask and op, then go to DECODE.
  - device_address is driven from the latch register, so it changes only on accept.
- DECODE (one cycle):
  - Sample device_active.
  - No bit set: go to RESP with error=1, rdata=0.
  - Otherwise: sel = lowest set index (multiple matches resolve to the lowest index), go to ACCESS.
- ACCESS (one cycle):
  - Assert device_ren[sel] or device_wen[sel] only; all other strobes stay 0.
  - Clear the counter, go to WAIT.
- WAIT:
  - device_ready[sel]=1: capture device_data_read[sel] for reads (0 for writes), error=0, go to RESP.
  - Ready from non-selected devices is ignored.
  - Counter increments each cycle. When TIMEOUT!=0 and counter==TIMEOUT-1 without ready: error=1, rdata={DATA_W{1'b1}}, go to RESP.
  - Ready and timeout in the same cycle: ready wins.
  - Ready arriving after a timeout, i.e. in any state other than WAIT, is ignored.
- RESP (one cycle):
  - host_ready=1 and host_error valid; go to IDLE.
  - host_data_read holds its value until the next RESP; host_error is 0 outside RESP.
- Latency:
  - Strobe in cycle 0 leads to the device strobe in cycle 2.
  - Earliest device ready is cycle 3, giving host_ready in cycle 4.
  - An unmapped access gives host_ready in cycle 2.
  - Devices must assert ready no earlier than the cycle after their strobe.
- Back-to-back: a new strobe in the cycle after host_ready is accepted, so one transaction completes per 5 cycles at most.
- Counter width: $clog2(TIMEOUT+1), minimum 1. It saturates and never wraps.

Decomposition:
- Shared package bus_hub_pkg:
  - hub_state_t enum {IDLE, DECODE, ACCESS, WAIT, RESP}
  - BUS_ERR_RDATA constant (all ones)
  - Helper function for mask width
- One sub-module, bus_prio_enc #(N): maps the active vector to {valid, index}, lowest index first.

Test Plan:
- NDEV=3, dev1 active for 0x1000, ready 1 cycle after strobe, rdata 0xDEADBEEF. Read at cycle 0 -> device_ren=3'b010 at cycle 2; host_ready at cycle 4 with 0xDEADBEEF, error=0.
- Write 0x12345678, mask 4'b0011 to dev0 -> device_wen=3'b001 once; device sees the latched data and mask; host_ready with rdata=0, error=0.
- Address with no active bit -> host_ready at cycle 2, error=1, rdata=0; no device strobe ever asserted.
- TIMEOUT=8, dev2 never ready -> host_ready 8 cycles after entering WAIT, error=1, rdata=0xFFFFFFFF. A dev2 ready injected later is ignored and host_busy stays 0.
- Two devices active simultaneously (dev0 and dev2) -> only dev0 is strobed. A host strobe issued while busy is dropped: exactly one host_ready is seen.
- rst_n pulled low during WAIT -> all outputs 0 immediately. After release, a fresh read completes normally with correct data.
